// File: rtl/background_pattern.sv
// background_pattern
// Per-pixel background colour generator for the VGA pipeline.
// Four patterns: horizontal bars, vertical bars, tile checkerboard and a
// horizontally scrolling checkerboard. Pattern changes take effect only at
// the end of a frame so a frame is never drawn with two patterns.
// Two register stages: stage 1 holds the decoded pixel attributes, stage 2
// holds the final colour.

module background_pattern #(
  parameter int HACTIVE     = 800,
  parameter int VACTIVE     = 600,
  parameter int NBARS       = 6,
  parameter int TILE_LOG2   = 5,
  parameter int SCROLL_STEP = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic signed [10:0] spotX,
  input  logic signed [10:0] spotY,
  input  logic        [1:0]  mode_req,
  input  logic               mode_load,
  output logic        [1:0]  mode_active,
  output logic        [7:0]  bck_r,
  output logic        [7:0]  bck_g,
  output logic        [7:0]  bck_b
);

  // Scroll counter is two tiles wide so the scrolled pattern repeats cleanly.
  localparam int SW = TILE_LOG2 + 1;

  localparam logic [23:0] COL_LIGHT = 24'hC0C0C0;
  localparam logic [23:0] COL_DARK  = 24'h404040;
  localparam logic [23:0] COL_BLACK = 24'h000000;

  // Bar boundary k of NBARS across an extent, rounded down.
  function automatic logic [10:0] bar_threshold(input int k, input int extent);
    return 11'((k * extent) / NBARS);
  endfunction

  // Bar palette cycles through six saturated colours.
  function automatic logic [23:0] bar_colour(input logic [5:0] idx);
    logic [23:0] col;
    case (idx % 6'd6)
      6'd0:    col = 24'hFF0000;
      6'd1:    col = 24'h00FF00;
      6'd2:    col = 24'h0000FF;
      6'd3:    col = 24'hFFFF00;
      6'd4:    col = 24'hFF00FF;
      6'd5:    col = 24'h00FFFF;
      default: col = COL_BLACK;
    endcase
    return col;
  endfunction

  // Checker parity: tile column bit XOR tile row bit.
  function automatic logic tile_parity(input logic [11:0] x, input logic [10:0] y);
    return x[TILE_LOG2] ^ y[TILE_LOG2];
  endfunction

  // Frame-level state
  logic [1:0]    r_mode_active;
  logic [1:0]    r_mode_pending;
  logic [SW-1:0] r_scroll;

  // Stage 1 registers
  logic          r_s1_active;
  logic [5:0]    r_s1_hbar;
  logic [5:0]    r_s1_vbar;
  logic          r_s1_par;
  logic [1:0]    r_s1_mode;

  // Stage 2 registers
  logic [7:0]    r_bck_r;
  logic [7:0]    r_bck_g;
  logic [7:0]    r_bck_b;

  // Combinational decode of the incoming coordinates
  logic          w_active;
  logic          w_frame_end;
  logic [5:0]    w_hbar;
  logic [5:0]    w_vbar;
  logic [11:0]   w_xs;
  logic          w_par;
  logic          w_spar;
  logic [23:0]   w_colour;

  // Negative coordinates are rejected via the sign bit before the upper bound test.
  assign w_active = !spotX[10] && ($unsigned(spotX) < 11'(HACTIVE)) &&
                    !spotY[10] && ($unsigned(spotY) < 11'(VACTIVE));

  assign w_frame_end = ($unsigned(spotX) == 11'(HACTIVE - 1)) &&
                       ($unsigned(spotY) == 11'(VACTIVE - 1));

  // Scrolled column uses 12-bit unsigned arithmetic; only meaningful in the active area.
  assign w_xs   = {1'b0, $unsigned(spotX)} + 12'(r_scroll);
  assign w_par  = tile_parity({1'b0, $unsigned(spotX)}, $unsigned(spotY));
  assign w_spar = tile_parity(w_xs, $unsigned(spotY));

  // Bar index = number of bar boundaries at or before the coordinate.
  always_comb begin
    w_hbar = 6'd0;
    w_vbar = 6'd0;
    for (int k = 1; k < NBARS; k++) begin
      if ($unsigned(spotY) >= bar_threshold(k, VACTIVE)) begin
        w_hbar = w_hbar + 6'd1;
      end else begin
        w_hbar = w_hbar;
      end
      if ($unsigned(spotX) >= bar_threshold(k, HACTIVE)) begin
        w_vbar = w_vbar + 6'd1;
      end else begin
        w_vbar = w_vbar;
      end
    end
  end

  // Frame-synchronous mode switching and per-frame scroll advance.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_mode_active  <= 2'd0;
      r_mode_pending <= 2'd0;
      r_scroll       <= '0;
    end else begin
      if (mode_load) begin
        r_mode_pending <= mode_req;
      end
      if (w_frame_end) begin
        r_mode_active <= mode_load ? mode_req : r_mode_pending;
        r_scroll      <= r_scroll + SW'(SCROLL_STEP);
      end
    end
  end

  // Stage 1: capture pixel attributes with the mode and scroll in force now.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_s1_active <= 1'b0;
      r_s1_hbar   <= 6'd0;
      r_s1_vbar   <= 6'd0;
      r_s1_par    <= 1'b0;
      r_s1_mode   <= 2'd0;
    end else begin
      r_s1_active <= w_active;
      r_s1_hbar   <= w_hbar;
      r_s1_vbar   <= w_vbar;
      r_s1_par    <= (r_mode_active == 2'd3) ? w_spar : w_par;
      r_s1_mode   <= r_mode_active;
    end
  end

  // Colour selection from the stage 1 attributes.
  always_comb begin
    if (!r_s1_active) begin
      w_colour = COL_BLACK;
    end else begin
      case (r_s1_mode)
        2'd0:    w_colour = bar_colour(r_s1_hbar);
        2'd1:    w_colour = bar_colour(r_s1_vbar);
        2'd2:    w_colour = r_s1_par ? COL_DARK : COL_LIGHT;
        2'd3:    w_colour = r_s1_par ? COL_DARK : COL_LIGHT;
        default: w_colour = COL_BLACK;
      endcase
    end
  end

  // Stage 2: register the final colour.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_bck_r <= 8'd0;
      r_bck_g <= 8'd0;
      r_bck_b <= 8'd0;
    end else begin
      r_bck_r <= w_colour[23:16];
      r_bck_g <= w_colour[15:8];
      r_bck_b <= w_colour[7:0];
    end
  end

  assign mode_active = r_mode_active;
  assign bck_r       = r_bck_r;
  assign bck_g       = r_bck_g;
  assign bck_b       = r_bck_b;

endmodule

// File: tb/tb_background_pattern.sv
// tb_background_pattern
// Directed boundary tests plus randomized traffic, checked every cycle
// against a pixel-level reference model of the background generator.

module tb_background_pattern;

  localparam int HA = 800;
  localparam int VA = 600;
  localparam int NB = 6;
  localparam int TL = 5;
  localparam int ST = 1;

  logic               clk;
  logic               reset_n;
  logic signed [10:0] spotX;
  logic signed [10:0] spotY;
  logic        [1:0]  mode_req;
  logic               mode_load;
  logic        [1:0]  mode_active;
  logic        [7:0]  bck_r;
  logic        [7:0]  bck_g;
  logic        [7:0]  bck_b;

  int n_tests;
  int n_fail;

  // Reference model state
  int m_mode;
  int m_pending;
  int m_scroll;
  int m_d1;
  int m_out;

  int palette [6] = '{32'hFF0000, 32'h00FF00, 32'h0000FF,
                      32'hFFFF00, 32'hFF00FF, 32'h00FFFF};

  background_pattern #(
    .HACTIVE(HA), .VACTIVE(VA), .NBARS(NB), .TILE_LOG2(TL), .SCROLL_STEP(ST)
  ) dut (
    .clk(clk), .reset_n(reset_n), .spotX(spotX), .spotY(spotY),
    .mode_req(mode_req), .mode_load(mode_load), .mode_active(mode_active),
    .bck_r(bck_r), .bck_g(bck_g), .bck_b(bck_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int bar_index(input int c, input int extent);
    int b = 0;
    for (int k = 1; k < NB; k++)
      if (c >= (k * extent) / NB) b++;
    return b;
  endfunction

  function automatic int ref_colour(input int x, input int y, input int mode, input int scroll);
    int tile = 1 << TL;
    int p;
    if (x < 0 || x >= HA || y < 0 || y >= VA) return 0;
    case (mode)
      0: return palette[bar_index(y, VA) % 6];
      1: return palette[bar_index(x, HA) % 6];
      2: p = ((x / tile) + (y / tile)) % 2;
      default: p = ((((x + scroll) % 4096) / tile) + (y / tile)) % 2;
    endcase
    return p ? 32'h404040 : 32'hC0C0C0;
  endfunction

  // One pixel clock: present inputs, advance model, check outputs after the edge.
  task automatic cycle(input int x, input int y, input logic ld, input int rq);
    int col;
    bit fe;
    spotX     = 11'(x);
    spotY     = 11'(y);
    mode_load = ld;
    mode_req  = 2'(rq);
    col = ref_colour(x, y, m_mode, m_scroll);
    fe  = (x == HA - 1) && (y == VA - 1);
    @(posedge clk);
    if (!reset_n) begin
      m_mode = 0; m_pending = 0; m_scroll = 0; m_d1 = 0; m_out = 0;
    end else begin
      m_out = m_d1;
      m_d1  = col;
      if (fe) begin
        m_mode   = ld ? rq : m_pending;
        m_scroll = (m_scroll + ST) % (2 << TL);
      end
      if (ld) m_pending = rq;
    end
    #1;
    check("bck", {8'h00, bck_r, bck_g, bck_b}, 32'(m_out));
    check("mode_active", 32'(mode_active), 32'(m_mode));
  endtask

  task automatic flush();
    cycle(10, 10, 1'b0, 0);
    cycle(10, 10, 1'b0, 0);
  endtask

  task automatic set_mode(input int md);
    cycle(5, 5, 1'b1, md);
    cycle(HA - 1, VA - 1, 1'b0, 0);
    flush();
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    m_mode = 0; m_pending = 0; m_scroll = 0; m_d1 = 0; m_out = 0;
    reset_n = 1'b0; spotX = 11'sd10; spotY = 11'sd10; mode_req = 2'd0; mode_load = 1'b0;

    // Reset held for three cycles, then release and watch red appear
    repeat (3) cycle(10, 10, 1'b0, 0);
    reset_n = 1'b1;
    cycle(10, 10, 1'b0, 0);
    check("post_reset_black", {8'h00, bck_r, bck_g, bck_b}, 32'h0);
    cycle(10, 10, 1'b0, 0);
    cycle(10, 10, 1'b0, 0);
    check("first_red", {8'h00, bck_r, bck_g, bck_b}, 32'hFF0000);

    // Horizontal bar boundaries
    foreach (palette[i]) begin end
    cycle(400, 99, 1'b0, 0);
    cycle(400, 100, 1'b0, 0);
    cycle(400, 299, 1'b0, 0);
    cycle(400, 300, 1'b0, 0);
    cycle(400, 599, 1'b0, 0);
    flush();

    // Deferred mode change to vertical bars
    cycle(5, 200, 1'b1, 1);
    cycle(400, 400, 1'b0, 0);
    check("defer_hold", 32'(mode_active), 32'h0);
    cycle(HA - 1, VA - 1, 1'b0, 0);
    cycle(0, 0, 1'b0, 0);
    cycle(133, 0, 1'b0, 0);
    cycle(134, 0, 1'b0, 0);
    flush();
    check("defer_applied", 32'(mode_active), 32'h1);

    // Checkerboard
    set_mode(2);
    cycle(31, 0, 1'b0, 0);
    cycle(32, 0, 1'b0, 0);
    cycle(32, 32, 1'b0, 0);
    cycle(0, 32, 1'b0, 0);
    flush();

    // Scroll checkerboard from a clean scroll origin
    reset_n = 1'b0; cycle(10, 10, 1'b0, 0); reset_n = 1'b1;
    cycle(HA - 1, VA - 1, 1'b1, 3);
    for (int n = 2; n <= 64; n++) begin
      cycle(HA - 1, VA - 1, 1'b0, 0);
      if (n == 31 || n == 32 || n == 64) begin
        cycle(0, 0, 1'b0, 0);
        flush();
      end
    end

    // Blanking in every mode
    for (int md = 0; md < 4; md++) begin
      set_mode(md);
      cycle(-1, 10, 1'b0, 0);
      cycle(HA, 10, 1'b0, 0);
      cycle(10, VA, 1'b0, 0);
      cycle(10, -1, 1'b0, 0);
      cycle(-1024, -1024, 1'b0, 0);
      flush();
    end

    // Load in the frame-end cycle, then reset after a pending load
    cycle(HA - 1, VA - 1, 1'b1, 2);
    check("fe_load", 32'(mode_active), 32'h2);
    cycle(40, 40, 1'b1, 1);
    reset_n = 1'b0; cycle(50, 50, 1'b0, 0); reset_n = 1'b1;
    check("reset_mode", 32'(mode_active), 32'h0);
    cycle(HA - 1, VA - 1, 1'b0, 0);
    flush();

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      int x, y, rq;
      logic ld;
      x  = int'($urandom_range(0, 859)) - 30;
      y  = int'($urandom_range(0, 659)) - 30;
      if ($urandom_range(0, 19) == 0) begin x = HA - 1; y = VA - 1; end
      ld = ($urandom_range(0, 9) == 0);
      rq = int'($urandom_range(0, 3));
      reset_n = ($urandom_range(0, 199) != 0);
      cycle(x, y, ld, rq);
    end
    reset_n = 1'b1;
    flush();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
